// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner: FSM state encoding,
// key-code constants and the row/column to key-code map.
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN      = 2'd0,
      DEB_PRESS = 2'd1,
      PRESSED   = 2'd2,
      DEB_REL   = 2'd3
   } state_t;

   // Non-digit key codes; digit keys encode as their own value.
   localparam logic [3:0] KEY_A    = 4'd10;
   localparam logic [3:0] KEY_B    = 4'd11;
   localparam logic [3:0] KEY_C    = 4'd12;
   localparam logic [3:0] KEY_D    = 4'd13;
   localparam logic [3:0] KEY_STAR = 4'd14;
   localparam logic [3:0] KEY_HASH = 4'd15;

   // Column pattern driven right after reset (column 0 low).
   localparam logic [3:0] COL_RESET = 4'b1110;

   // Physical layout:
   //   r0: 1 2 3 A   r1: 4 5 6 B   r2: 7 8 9 C   r3: * 0 # D
   function automatic logic [3:0] keymap(input logic [1:0] row_idx,
                                         input logic [1:0] col_idx);
      logic [3:0] code;
      case ({row_idx, col_idx})
         4'b00_00: code = 4'd1;
         4'b00_01: code = 4'd2;
         4'b00_10: code = 4'd3;
         4'b00_11: code = KEY_A;
         4'b01_00: code = 4'd4;
         4'b01_01: code = 4'd5;
         4'b01_10: code = 4'd6;
         4'b01_11: code = KEY_B;
         4'b10_00: code = 4'd7;
         4'b10_01: code = 4'd8;
         4'b10_10: code = 4'd9;
         4'b10_11: code = KEY_C;
         4'b11_00: code = KEY_STAR;
         4'b11_01: code = 4'd0;
         4'b11_10: code = KEY_HASH;
         default:  code = KEY_D;
      endcase
      return code;
   endfunction

   // Index of the lowest active-low bit; several rows low resolve to the
   // lowest row so a multi-key chord in one column still yields one key.
   function automatic logic [1:0] low_index(input logic [3:0] v);
      logic [1:0] idx;
      if (!v[0])      idx = 2'd0;
      else if (!v[1]) idx = 2'd1;
      else if (!v[2]) idx = 2'd2;
      else            idx = 2'd3;
      return idx;
   endfunction

   // Advance the single low column bit: 1110 -> 1101 -> 1011 -> 0111 -> 1110.
   function automatic logic [3:0] rotate_col(input logic [3:0] c);
      return {c[2:0], c[3]};
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for the keypad rows. Resets to all-ones, which is
// the idle (no key) level of the pulled-up, active-low rows.
module sync_2ff #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta;

   // Two back-to-back flops; only q is used downstream.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta <= '1;
         q    <= '1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks a single low column, debounces the
// press and the release, and presents a key code (tecla) that stays put
// across and after the ready pulse so a downstream FSM can latch it on
// ready fall.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV     = 16,
   parameter int DEBOUNCE_CNT = 50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic [3:0] tecla,
   output logic       ready
);

   localparam int DW = $clog2(SCAN_DIV);
   localparam int CW = $clog2(DEBOUNCE_CNT);

   localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CNT - 1);

   state_t        state;
   logic [3:0]    rs;        // synchronized rows; the only row view used
   logic [DW-1:0] dwell;
   logic [CW-1:0] cnt;
   logic [3:0]    cap_rs;    // row pattern seen at dwell end
   logic [1:0]    cap_row;
   logic [1:0]    cap_col;
   logic          rs_idle;
   logic          cnt_done;

   sync_2ff #(.W(4)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (row),
      .q     (rs)
   );

   // Shared decode of the row view and debounce terminal count.
   always_comb begin
      rs_idle  = (rs == 4'hF);
      cnt_done = (cnt == CNT_LAST);
   end

   // Scan / debounce FSM. tecla is written only on press acceptance, so it
   // is steady for the whole ready pulse and on the edge where ready drops.
   // The counters never pass their terminal value: dwell clears at
   // DWELL_LAST and cnt only increments below CNT_LAST.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= SCAN;
         col     <= COL_RESET;
         dwell   <= '0;
         cnt     <= '0;
         tecla   <= 4'd0;
         ready   <= 1'b0;
         cap_rs  <= 4'hF;
         cap_row <= 2'd0;
         cap_col <= 2'd0;
      end else begin
         case (state)
            SCAN: begin
               if (dwell == DWELL_LAST) begin
                  dwell <= '0;
                  if (rs_idle) begin
                     col <= rotate_col(col);
                  end else begin
                     // Column stays driven so the debounce sees the same key.
                     cap_rs  <= rs;
                     cap_row <= low_index(rs);
                     cap_col <= low_index(col);
                     cnt     <= '0;
                     state   <= DEB_PRESS;
                  end
               end else begin
                  dwell <= dwell + DW'(1);
               end
            end

            DEB_PRESS: begin
               if (rs != cap_rs) begin
                  // Bounce: restart the dwell on the same column.
                  cnt   <= '0;
                  dwell <= '0;
                  state <= SCAN;
               end else if (cnt_done) begin
                  tecla <= keymap(cap_row, cap_col);
                  ready <= 1'b1;
                  state <= PRESSED;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end

            PRESSED: begin
               if (rs_idle) begin
                  cnt   <= '0;
                  state <= DEB_REL;
               end
            end

            DEB_REL: begin
               if (!rs_idle) begin
                  cnt   <= '0;
                  state <= PRESSED;
               end else if (cnt_done) begin
                  ready <= 1'b0;
                  col   <= rotate_col(col);
                  dwell <= '0;
                  cnt   <= '0;
                  state <= SCAN;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end

            default: begin
               state <= SCAN;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CNT=8.
// A behavioural keypad pulls row[r] low while column c is driven low and
// key (r,c) is held. Cycle numbers below count posedges after reset release.
module tb_keypad_scanner;

   logic       clk;
   logic       reset;
   logic [3:0] row;
   logic [3:0] col;
   logic [3:0] tecla;
   logic       ready;

   logic [15:0] keys;   // bit r*4+c set = key (r,c) held

   int n_cmp;
   int n_err;

   keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(8)) dut (
      .clk   (clk),
      .reset (reset),
      .row   (row),
      .col   (col),
      .tecla (tecla),
      .ready (ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural matrix keypad.
   always_comb begin
      row = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] key(input int r, input int c);
      logic [15:0] one;
      one = 16'd1;
      return one << (r*4 + c);
   endfunction

   // Advance n posedges and settle 1 time unit past the last one.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Hold reset over two edges and release it mid-cycle.
   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic wait_ready(input logic v, input int max, input string tag);
      int n;
      n = 0;
      while (ready !== v && n < max) begin
         tick(1);
         n++;
      end
      chk(tag, ready, v);
   endtask

   logic [3:0] colseq [4];
   logic       bad;
   logic       seen;

   initial begin
      n_cmp = 0;
      n_err = 0;
      keys  = '0;
      reset = 1'b1;
      colseq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

      // 1. Reset state and free-running column walk.
      #12;
      chk("rst_col", col, 4'b1110);
      chk("rst_rdy", ready, 0);
      chk("rst_tecla", tecla, 0);
      do_reset();
      for (int k = 1; k <= 16; k++) begin
         tick(1);
         chk($sformatf("walk_col_%0d", k), col, colseq[(k/4)%4]);
      end

      // 2. Hold '5': col1 low after edge 4, rs low after 6, detect at 8,
      //    ready after edge 16.
      keys = key(1, 1);
      do_reset();
      tick(15);
      chk("p5_rdy_early", ready, 0);
      tick(1);
      chk("p5_rdy", ready, 1);
      chk("p5_tecla", tecla, 5);
      chk("p5_col", col, 4'b1101);
      tick(24);                                  // edge 40
      chk("p5_hold_col", col, 4'b1101);
      chk("p5_hold_rdy", ready, 1);

      // 4. Release with bounce: high after 40, low after 41, high after 42.
      //    rs settles high after 44, DEB_REL entered at 45, ready falls at 53.
      keys = '0;
      tick(1);
      keys = key(1, 1);
      tick(1);
      keys = '0;
      tick(10);                                  // edge 52
      chk("rel_rdy_hold", ready, 1);
      chk("rel_tecla_hold", tecla, 5);
      tick(1);                                   // edge 53
      chk("rel_rdy_fall", ready, 0);
      chk("rel_tecla_after", tecla, 5);
      chk("rel_col_next", col, 4'b1011);

      // 3. '7' bouncing 3 low / 2 high never survives debounce.
      bad = 1'b0;
      for (int i = 0; i < 60; i++) begin
         keys = ((i % 5) < 3) ? key(2, 0) : 16'd0;
         tick(1);
         if (ready !== 1'b0) bad = 1'b1;
      end
      chk("bounce_no_rdy", bad, 0);
      chk("bounce_tecla", tecla, 5);
      keys = '0;
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         tick(1);
         if (col == 4'b1101) seen = 1'b1;
      end
      chk("bounce_scan_resumes", seen, 1);

      // 5. Other keys, including a same-column chord.
      keys = key(3, 2);
      wait_ready(1, 100, "hash_rdy");
      chk("hash_tecla", tecla, 15);
      keys = '0;
      wait_ready(0, 100, "hash_rel");
      chk("hash_tecla_after", tecla, 15);

      keys = key(3, 3);
      wait_ready(1, 100, "d_rdy");
      chk("d_tecla", tecla, 13);
      keys = '0;
      wait_ready(0, 100, "d_rel");
      chk("d_tecla_after", tecla, 13);

      keys = key(0, 0) | key(2, 0);
      wait_ready(1, 100, "chord_rdy");
      chk("chord_tecla", tecla, 1);
      keys = '0;
      wait_ready(0, 100, "chord_rel");
      chk("chord_tecla_after", tecla, 1);

      // 6. Asynchronous reset while '9' is held and accepted.
      keys = key(2, 2);
      wait_ready(1, 100, "p9_rdy");
      chk("p9_tecla", tecla, 9);
      #3;
      reset = 1'b1;
      #1;
      chk("arst_rdy", ready, 0);
      chk("arst_tecla", tecla, 0);
      chk("arst_col", col, 4'b1110);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      // col2 low after edge 8, detect at 12, ready after edge 20.
      tick(19);
      chk("arst_no_rdy", ready, 0);
      chk("arst_tecla_hold", tecla, 0);
      tick(1);
      chk("arst_new_rdy", ready, 1);
      chk("arst_new_tecla", tecla, 9);
      chk("arst_new_col", col, 4'b1011);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
